// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and FSM state encodings, flag bundle.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ILL0 = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_INC  = 4'h3,
    OP_DEC  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_ONES = 4'hA,
    OP_TWOS = 4'hB,
    OP_ROL  = 4'hC,
    OP_ROR  = 4'hD,
    OP_MUL  = 4'hE,
    OP_ILLF = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    logic err;
  } alu_flags_t;

  // Flag set reported for opcodes outside the decode table.
  function automatic alu_flags_t illegal_flags();
    alu_flags_t f;
    f     = '0;
    f.err = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned WIDTHxWIDTH shift-add multiplier, one partial product per cycle.
// done_c/product_c are valid during the final step so the caller can load on that edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned LAST  = WIDTH - 1;
  localparam int unsigned PW    = 2 * WIDTH;

  logic              busy_q,   busy_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [PW-1:0]     acc_q,    acc_d;
  logic [PW-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_step_c;

  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_step_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_c     = busy_q && (cnt_q == CNT_W'(LAST));
    product_c  = acc_step_c;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_step_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done_c) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops complete in one edge, mul iterates WIDTH edges
// in a sub-module; a single output register holds the result until consumed.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [OP_W-1:0]      opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     alu_out,
  output logic                 alu_zero,
  output logic                 alu_carry,
  output logic                 alu_ovf,
  output logic                 alu_neg,
  output logic                 alu_err
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_X = (WIDTH + 1)'(1);

  alu_state_e          state_q, state_d;
  logic [WIDTH-1:0]    out_q, out_d;
  alu_flags_t          flags_q, flags_d;
  logic                out_valid_q, out_valid_d;

  alu_op_e             op_c;
  logic                accept_c;
  logic                mul_start_c;
  logic                mul_done_c;
  logic [2*WIDTH-1:0]  mul_prod_c;
  logic [WIDTH-1:0]    mul_res_c;
  alu_flags_t          mul_flags_c;
  logic [WIDTH:0]      sum_c;
  logic [WIDTH-1:0]    alu_res_c;
  alu_flags_t          alu_flags_c;
  logic                legal_c;

  assign op_c     = alu_op_e'(opcode);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .a         (in_a),
    .b         (in_b),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Single-cycle datapath; arithmetic ops carry out of a WIDTH+1 bit sum.
  always_comb begin
    sum_c       = '0;
    alu_res_c   = '0;
    alu_flags_c = '0;
    legal_c     = 1'b1;
    case (op_c)
      OP_ADD: begin
        sum_c             = {1'b0, in_a} + {1'b0, in_b};
        alu_res_c         = sum_c[MSB:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = (in_a[MSB] == in_b[MSB]) && (sum_c[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        sum_c             = {1'b0, in_a} - {1'b0, in_b};
        alu_res_c         = sum_c[MSB:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = (in_a[MSB] != in_b[MSB]) && (sum_c[MSB] != in_a[MSB]);
      end
      OP_INC: begin
        sum_c             = {1'b0, in_a} + ONE_X;
        alu_res_c         = sum_c[MSB:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = !in_a[MSB] && sum_c[MSB];
      end
      OP_DEC: begin
        sum_c             = {1'b0, in_a} - ONE_X;
        alu_res_c         = sum_c[MSB:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = in_a[MSB] && !sum_c[MSB];
      end
      OP_TWOS: begin
        // ~a + 1 carries out only when a is zero.
        sum_c             = {1'b0, ~in_a} + ONE_X;
        alu_res_c         = sum_c[MSB:0];
        alu_flags_c.carry = sum_c[WIDTH];
        alu_flags_c.ovf   = in_a[MSB] && sum_c[MSB];
      end
      OP_OR:   alu_res_c = in_a | in_b;
      OP_AND:  alu_res_c = in_a & in_b;
      OP_XOR:  alu_res_c = in_a ^ in_b;
      OP_ONES: alu_res_c = ~in_a;
      OP_SHR: begin
        alu_res_c         = {1'b0, in_a[MSB:1]};
        alu_flags_c.carry = in_a[0];
      end
      OP_SHL: begin
        alu_res_c         = {in_a[MSB-1:0], 1'b0};
        alu_flags_c.carry = in_a[MSB];
      end
      OP_ROL: begin
        alu_res_c         = {in_a[MSB-1:0], in_a[MSB]};
        alu_flags_c.carry = in_a[MSB];
      end
      OP_ROR: begin
        alu_res_c         = {in_a[0], in_a[MSB:1]};
        alu_flags_c.carry = in_a[0];
      end
      OP_MUL:  alu_res_c = '0;
      default: legal_c = 1'b0;
    endcase
    if (legal_c) begin
      alu_flags_c.zero = (alu_res_c == '0);
      alu_flags_c.neg  = alu_res_c[MSB];
    end else begin
      alu_res_c   = '0;
      alu_flags_c = illegal_flags();
    end
  end

  always_comb begin
    mul_res_c         = mul_prod_c[MSB:0];
    mul_flags_c       = '0;
    mul_flags_c.carry = |mul_prod_c[2*WIDTH-1:WIDTH];
    mul_flags_c.ovf   = mul_flags_c.carry;
    mul_flags_c.zero  = (mul_res_c == '0);
    mul_flags_c.neg   = mul_res_c[MSB];
  end

  // Control FSM and output register load; the result stays put until out_ready.
  always_comb begin
    state_d     = state_q;
    mul_start_c = 1'b0;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (op_c == OP_MUL) begin
            state_d     = BUSY;
            mul_start_c = 1'b1;
          end else begin
            out_d       = alu_res_c;
            flags_d     = alu_flags_c;
            out_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mul_done_c) begin
          state_d     = IDLE;
          out_d       = mul_res_c;
          flags_d     = mul_flags_c;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = out_q;
  assign alu_zero  = flags_q.zero;
  assign alu_carry = flags_q.carry;
  assign alu_ovf   = flags_q.ovf;
  assign alu_neg   = flags_q.neg;
  assign alu_err   = flags_q.err;

endmodule
